// File: rtl/mux_pkg.sv
// Shared definitions for the two-source arbitrated multiplexer.
package mux_pkg;

  // Default data width for the mux and the arbiter.
  localparam int DEFAULT_WIDTH = 4;

  // Output-register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Mux select encodings.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Pick the winning source. A lone requester always wins.
  // When both request, the source that was not granted last wins.
  function automatic logic rr_pick(input logic a_valid,
                                   input logic b_valid,
                                   input logic last_sel);
    if (a_valid && b_valid) begin
      return (last_sel == SEL_A) ? SEL_B : SEL_A;
    end
    if (b_valid) begin
      return SEL_B;
    end
    return SEL_A;
  endfunction

endpackage

// File: rtl/mux.sv
// Plain 2:1 data multiplexer: Sel=0 passes A, Sel=1 passes B.
module mux #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] Out
);

  // Pure combinational select.
  assign Out = Sel ? B : A;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter between two valid/ready sources feeding a single
// registered output word. One word per cycle; the output register can drain
// and refill in the same cycle.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic             A_valid,
  output logic             A_ready,
  input  logic [WIDTH-1:0] B,
  input  logic             B_valid,
  output logic             B_ready,
  output logic             Sel,
  output logic [WIDTH-1:0] Out,
  output logic             Out_valid,
  input  logic             Out_ready
);

  // Registered state.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             sel_q,   sel_d;   // select of the most recent grant
  logic             last_q,  last_d;  // round-robin pointer

  // Arbitration terms.
  logic             load_en;
  logic             any_req;
  logic             grant;
  logic             win_sel;
  logic [WIDTH-1:0] mux_out;

  // The output register can take a new word when empty or when the current
  // word is being consumed this cycle. Reset blocks every grant so that the
  // ready outputs stay low for as long as Rst is high.
  always_comb begin
    load_en = (state_q == EMPTY) | Out_ready;
    any_req = A_valid | B_valid;
    grant   = ~Rst & load_en & any_req;
    win_sel = rr_pick(A_valid, B_valid, last_q);
  end

  // Handshake and select outputs; Sel follows the winner on a grant and
  // otherwise keeps showing the previous grant.
  always_comb begin
    A_ready = grant & (win_sel == SEL_A);
    B_ready = grant & (win_sel == SEL_B);
    Sel     = grant ? win_sel : sel_q;
  end

  // Data path: the selected source word.
  mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .A   (A),
    .B   (B),
    .Sel (Sel),
    .Out (mux_out)
  );

  // Next-state: load on grant, drain to empty when consumed with nothing new,
  // otherwise hold everything.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (grant) begin
      state_d = FULL;
      out_d   = mux_out;
      sel_d   = win_sel;
      last_d  = win_sel;
    end else if (load_en && Out_ready) begin
      state_d = EMPTY;
    end
  end

  // State register; the pointer resets to B so A wins the first contention.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      sel_q   <= SEL_A;
      last_q  <= SEL_B;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign Out       = out_q;
  assign Out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mux_arbiter;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] A, B;
  logic         A_valid, B_valid, Out_ready;
  logic         A_ready, B_ready, Sel, Out_valid;
  logic [W-1:0] Out;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .A         (A),
    .A_valid   (A_valid),
    .A_ready   (A_ready),
    .B         (B),
    .B_valid   (B_valid),
    .B_ready   (B_ready),
    .Sel       (Sel),
    .Out       (Out),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  always #5 Clk = ~Clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_full: a word is waiting at the output; m_out: that word;
  // m_last: who won last (0=A, 1=B); m_sel: select shown when idle.
  bit           m_full;
  logic [W-1:0] m_out;
  bit           m_last;
  bit           m_sel;
  bit           rst_evt;
  bit           prev_hold;
  logic [W-1:0] prev_out;
  int           cyc_n = 0;

  always @(posedge Rst) rst_evt = 1'b1;

  // Compare process: at every falling edge check the DUT against the model,
  // then advance the model to what the next rising edge must produce.
  initial begin
    forever begin
      @(negedge Clk);
      cyc_n++;
      if (Rst || rst_evt) begin
        rst_evt   = 1'b0;
        m_full    = 1'b0;
        m_out     = '0;
        m_last    = 1'b1;
        m_sel     = 1'b0;
        prev_hold = 1'b0;
        if (Rst) begin
          chk("rst_a_ready", 32'(A_ready), 32'd0);
          chk("rst_b_ready", 32'(B_ready), 32'd0);
          chk("rst_out_valid", 32'(Out_valid), 32'd0);
          chk("rst_out", 32'(Out), 32'd0);
          chk("rst_sel", 32'(Sel), 32'd0);
          continue;
        end
      end
      begin
        bit space, want, win;
        space = !m_full || Out_ready;
        want  = A_valid || B_valid;
        if (A_valid && B_valid) win = !m_last;
        else                    win = B_valid;
        chk("out_valid", 32'(Out_valid), 32'(m_full));
        chk("out", 32'(Out), 32'(m_out));
        chk("a_ready", 32'(A_ready), 32'(space && want && !win));
        chk("b_ready", 32'(B_ready), 32'(space && want && win));
        chk("sel", 32'(Sel), 32'((space && want) ? win : m_sel));
        // Invariants: never both ready; output frozen under backpressure.
        chk("assert_onehot_ready", 32'(A_ready && B_ready), 32'd0);
        if (prev_hold) begin
          chk("assert_out_stable", 32'(Out), 32'(prev_out));
          chk("assert_valid_stable", 32'(Out_valid), 32'd1);
        end
        prev_hold = Out_valid && !Out_ready;
        prev_out  = Out;
        if (space && want) begin
          m_full = 1'b1;
          m_out  = win ? B : A;
          m_last = win;
          m_sel  = win;
          $display("cycle %0d: grant %s word %h", cyc_n, win ? "B" : "A", win ? B : A);
        end else if (space && Out_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [W-1:0] a, input logic av,
                     input logic [W-1:0] b, input logic bv, input logic ordy);
    @(posedge Clk); #1;
    A = a; A_valid = av; B = b; B_valid = bv; Out_ready = ordy;
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst = 1'b1; A_valid = 1'b0; B_valid = 1'b0; Out_ready = 1'b0;
    @(negedge Clk);
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; A = '0; B = '0; A_valid = 1'b0; B_valid = 1'b0; Out_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // No grant on the first edge after reset with idle sources.
    cyc(4'b0000, 0, 4'b0000, 0, 1);
    @(negedge Clk); chk("lit_post_reset_empty", 32'(Out_valid), 32'd0);

    // Single source A.
    cyc(4'b1010, 1, 4'b0000, 0, 1);
    @(negedge Clk);
    chk("lit_single_a_ready", 32'(A_ready), 32'd1);
    chk("lit_single_sel", 32'(Sel), 32'd0);
    cyc(4'b0000, 0, 4'b0000, 0, 0);
    @(negedge Clk);
    chk("lit_single_out", 32'(Out), 32'hA);
    chk("lit_single_valid", 32'(Out_valid), 32'd1);
    $display("directed: single source done");

    // Contention from a fresh reset: A, B, A, B.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1010, 1, 4'b0101, 1, 1);
      @(negedge Clk);
      chk("lit_rr_a_ready", 32'(A_ready), 32'(i % 2 == 0));
      chk("lit_rr_b_ready", 32'(B_ready), 32'(i % 2 == 1));
      if (i > 0) chk("lit_rr_out", 32'(Out), (i % 2 == 1) ? 32'hA : 32'h5);
    end
    cyc(4'b0000, 0, 4'b0000, 0, 0);
    @(negedge Clk); chk("lit_rr_out_last", 32'(Out), 32'h5);
    $display("directed: contention done");

    // Backpressure with B waiting.
    cyc(4'b1111, 1, 4'b0000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 0, 4'b0011, 1, 0);
      @(negedge Clk);
      chk("lit_bp_out", 32'(Out), 32'hF);
      chk("lit_bp_b_ready", 32'(B_ready), 32'd0);
    end
    cyc(4'b0000, 0, 4'b0011, 1, 1);
    @(negedge Clk); chk("lit_bp_release_b_ready", 32'(B_ready), 32'd1);
    // Drain to empty.
    cyc(4'b0000, 0, 4'b0000, 0, 1);
    @(negedge Clk);
    chk("lit_bp_out_b", 32'(Out), 32'h3);
    chk("lit_drain_sel", 32'(Sel), 32'd1);
    cyc(4'b0000, 0, 4'b0000, 0, 0);
    @(negedge Clk);
    chk("lit_drain_valid", 32'(Out_valid), 32'd0);
    chk("lit_drain_sel_hold", 32'(Sel), 32'd1);
    $display("directed: backpressure and drain done");

    // Reset in the middle of a held word.
    cyc(4'b0101, 1, 4'b0000, 0, 1);
    cyc(4'b0000, 0, 4'b0000, 0, 0);
    @(negedge Clk); chk("lit_mid_out_before", 32'(Out), 32'h5);
    #2;
    Rst = 1'b1; A = 4'b1100; B = 4'b0011; A_valid = 1'b1; B_valid = 1'b1; Out_ready = 1'b1;
    #1;
    chk("lit_mid_rst_valid", 32'(Out_valid), 32'd0);
    chk("lit_mid_rst_out", 32'(Out), 32'd0);
    chk("lit_mid_rst_sel", 32'(Sel), 32'd0);
    chk("lit_mid_rst_ready", 32'(A_ready | B_ready), 32'd0);
    @(negedge Clk);
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    chk("lit_after_rst_a_wins", 32'(A_ready), 32'd1);
    chk("lit_after_rst_b_idle", 32'(B_ready), 32'd0);
    $display("directed: mid-transfer reset done");

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      @(posedge Clk); #1;
      Rst       = (!Rst && $urandom_range(0, 99) == 0);
      A         = W'($urandom);
      B         = W'($urandom);
      A_valid   = ($urandom_range(0, 9) < 7);
      B_valid   = ($urandom_range(0, 9) < 6);
      Out_ready = ($urandom_range(0, 9) < 6);
    end
    @(posedge Clk); #1 Rst = 1'b0; A_valid = 1'b0; B_valid = 1'b0;
    repeat (2) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
